// File: rtl/kmeans_ctrl_pkg.sv
// rtl/kmeans_ctrl_pkg.sv - shared widths, state encoding and saturating add for kmeans_ctrl
package kmeans_ctrl_pkg;

    localparam int RGB_W    = 24;
    localparam int DIST_W   = 10;
    localparam int IDX_W    = 3;
    localparam int NUM_CENT = 8;
    localparam int RES_W    = IDX_W + DIST_W;
    localparam int SUM_W    = 26;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD_C,
        RUN,
        DRAIN,
        DONE
    } state_e;

    function automatic logic [SUM_W-1:0] sat_add(input logic [SUM_W-1:0]  a,
                                                 input logic [DIST_W-1:0] b);
        logic [SUM_W:0] s;
        s = {1'b0, a} + {{(SUM_W + 1 - DIST_W){1'b0}}, b};
        return s[SUM_W] ? {SUM_W{1'b1}} : s[SUM_W-1:0];
    endfunction

endpackage

// File: rtl/res_fifo.sv
// rtl/res_fifo.sv - in-order result FIFO with simultaneous push/pop
module res_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 13
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             pop_data,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
    logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]            count_q, count_d;
    logic                        do_push, do_pop;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign empty    = (count_q == '0);
    assign count    = count_q;

endmodule

// File: rtl/kmeans_ctrl.sv
// rtl/kmeans_ctrl.sv - frame sequencer for the k-means distance/min datapath
module kmeans_ctrl
    import kmeans_ctrl_pkg::*;
#(
    parameter int LAT        = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int NPIX_W     = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [NPIX_W-1:0]         num_pix,
    input  logic                      cent_valid,
    output logic                      cent_ready,
    input  logic [RGB_W-1:0]          cent_data,
    input  logic                      pix_valid,
    output logic                      pix_ready,
    input  logic [RGB_W-1:0]          pix_data,
    output logic                      dp_clear,
    output logic                      dp_c_en,
    output logic                      dp_if_en,
    output logic [NUM_CENT*RGB_W-1:0] dp_c_bus,
    output logic [RGB_W-1:0]          dp_if_in,
    input  logic [IDX_W-1:0]          dp_index,
    input  logic [DIST_W-1:0]         dp_distance,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [IDX_W-1:0]          res_index,
    output logic [DIST_W-1:0]         res_distance,
    output logic                      busy,
    output logic                      done,
    output logic [SUM_W-1:0]          dist_sum
);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int BEAT_W = $clog2(NUM_CENT);

    state_e                         state_q, state_d;
    logic [NPIX_W-1:0]              num_pix_q, num_pix_d;
    logic [NPIX_W-1:0]              issued_q, issued_d;
    logic [BEAT_W-1:0]              beat_q, beat_d;
    logic [NUM_CENT-1:0][RGB_W-1:0] cent_q, cent_d;
    logic [LAT-1:0]                 vld_q, vld_d;
    logic [SUM_W-1:0]               dist_sum_q, dist_sum_d;
    logic                           dp_c_en_q, dp_c_en_d;

    logic [CNT_W-1:0]               fifo_count;
    logic                           fifo_empty;
    logic [RES_W-1:0]               fifo_dout;
    logic                           push, pop, pix_fire, fifo_empty_next;
    logic [7:0]                     inflight, occupancy;

    res_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (RES_W)
    ) u_res_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({dp_index, dp_distance}),
        .pop       (pop),
        .pop_data  (fifo_dout),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Every output is forced low while rst is high, including the combinational handshakes.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < LAT; i++) begin
            inflight = inflight + 8'(vld_q[i]);
        end
        occupancy = 8'(fifo_count) + inflight;

        // The dp_c_en cycle is kept free of pixels so none races the centroid load.
        pix_ready    = !rst && (state_q == RUN) && !dp_c_en_q &&
                       (issued_q < num_pix_q) && (occupancy < 8'(FIFO_DEPTH));
        pix_fire     = pix_valid && pix_ready;
        dp_if_en     = pix_fire;
        dp_if_in     = pix_fire ? pix_data : '0;
        cent_ready   = !rst && (state_q == LOAD_C);
        dp_clear     = !rst && (state_q == CLEAR);
        dp_c_en      = !rst && dp_c_en_q;
        dp_c_bus     = rst ? '0 : cent_q;
        push         = vld_q[LAT-1];
        res_valid    = !rst && !fifo_empty;
        pop          = res_valid && res_ready;
        res_index    = res_valid ? fifo_dout[RES_W-1:DIST_W] : '0;
        res_distance = res_valid ? fifo_dout[DIST_W-1:0] : '0;
        busy         = !rst && (state_q != IDLE);
        done         = !rst && (state_q == DONE);
        dist_sum     = rst ? '0 : dist_sum_q;
    end

    // DRAIN looks one cycle ahead so done lands LAT+2 cycles after the last accept.
    assign fifo_empty_next = !push && ((fifo_count == '0) ||
                                       ((fifo_count == CNT_W'(1)) && pop));

    always_comb begin
        state_d    = state_q;
        num_pix_d  = num_pix_q;
        issued_d   = issued_q;
        beat_d     = beat_q;
        cent_d     = cent_q;
        dist_sum_d = dist_sum_q;
        dp_c_en_d  = 1'b0;

        vld_d[0] = pix_fire;
        for (int i = 1; i < LAT; i++) begin
            vld_d[i] = vld_q[i-1];
        end

        if (pop) begin
            dist_sum_d = sat_add(dist_sum_q, res_distance);
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    num_pix_d  = num_pix;
                    issued_d   = '0;
                    dist_sum_d = '0;
                    state_d    = CLEAR;
                end
            end
            CLEAR: begin
                beat_d  = '0;
                state_d = LOAD_C;
            end
            LOAD_C: begin
                if (cent_valid) begin
                    cent_d[beat_q] = cent_data;
                    beat_d         = beat_q + 1'b1;
                    if (beat_q == BEAT_W'(NUM_CENT - 1)) begin
                        dp_c_en_d = 1'b1;
                        state_d   = RUN;
                    end
                end
            end
            RUN: begin
                if (pix_fire) begin
                    issued_d = issued_q + 1'b1;
                end
                if (issued_q == num_pix_q) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if ((vld_d == '0) && fifo_empty_next) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            num_pix_q  <= '0;
            issued_q   <= '0;
            beat_q     <= '0;
            cent_q     <= '0;
            vld_q      <= '0;
            dist_sum_q <= '0;
            dp_c_en_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            num_pix_q  <= num_pix_d;
            issued_q   <= issued_d;
            beat_q     <= beat_d;
            cent_q     <= cent_d;
            vld_q      <= vld_d;
            dist_sum_q <= dist_sum_d;
            dp_c_en_q  <= dp_c_en_d;
        end
    end

endmodule

// File: tb/tb_kmeans_ctrl.sv
// tb/tb_kmeans_ctrl.sv - self-checking bench for kmeans_ctrl against a frame-level model
module tb_kmeans_ctrl;
    localparam int LAT        = 2;
    localparam int FIFO_DEPTH = 4;
    localparam int NPIX_W     = 17;
    localparam longint SUM_MAX = 64'h3FFFFFF;
    localparam int BIG_N      = 65610;

    logic               clk = 1'b0;
    logic               rst, start, cent_valid, pix_valid, res_ready;
    logic [NPIX_W-1:0]  num_pix;
    logic [23:0]        cent_data, pix_data, dp_if_in;
    logic               cent_ready, pix_ready, dp_clear, dp_c_en, dp_if_en;
    logic [191:0]       dp_c_bus;
    logic [2:0]         dp_index, res_index;
    logic [9:0]         dp_distance, res_distance;
    logic               res_valid, busy, done;
    logic [25:0]        dist_sum;

    always #5 clk = ~clk;

    kmeans_ctrl #(.LAT(LAT), .FIFO_DEPTH(FIFO_DEPTH), .NPIX_W(NPIX_W)) dut (
        .clk(clk), .rst(rst), .start(start), .num_pix(num_pix),
        .cent_valid(cent_valid), .cent_ready(cent_ready), .cent_data(cent_data),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .dp_clear(dp_clear), .dp_c_en(dp_c_en), .dp_if_en(dp_if_en),
        .dp_c_bus(dp_c_bus), .dp_if_in(dp_if_in),
        .dp_index(dp_index), .dp_distance(dp_distance),
        .res_valid(res_valid), .res_ready(res_ready), .res_index(res_index),
        .res_distance(res_distance), .busy(busy), .done(done), .dist_sum(dist_sum)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int mdist(input logic [23:0] a, input logic [23:0] b);
        int d;
        d = 0;
        for (int c = 0; c < 3; c++) begin
            int x, y;
            x = int'(a[8*c +: 8]);
            y = int'(b[8*c +: 8]);
            d += (x > y) ? x - y : y - x;
        end
        return d;
    endfunction

    // Nearest centroid by Manhattan RGB distance, lowest index wins ties.
    function automatic logic [12:0] nearest(input logic [23:0] p, input logic [191:0] cb);
        int best, bi, d;
        best = 1 << 30;
        bi   = 0;
        for (int k = 0; k < 8; k++) begin
            d = mdist(p, cb[24*k +: 24]);
            if (d < best) begin
                best = d;
                bi   = k;
            end
        end
        return {bi[2:0], best[9:0]};
    endfunction

    function automatic logic [23:0] pix_pat(input int sel, input int i);
        logic [23:0] lst [4];
        lst = '{24'h000000, 24'h070707, 24'h030405, 24'hFFFFFF};
        case (sel)
            0:       return (i < 4) ? lst[i] : 24'h0;
            1:       return 24'(i * 32'h001F2E3D);
            default: return 24'(i * 32'h00010307);
        endcase
    endfunction

    logic [191:0] cent_tab;
    bit           force_max = 1'b0;

    // Datapath stand-in: answers LAT cycles after dp_if_en, using the bus it was handed.
    logic [191:0] dp_cent_m = '0;
    logic         en_s = 1'b0;
    logic [23:0]  in_s = '0;
    logic [12:0]  pipe [LAT];
    always @(negedge clk) begin
        en_s = dp_if_en;
        in_s = dp_if_in;
        if (dp_c_en) dp_cent_m = dp_c_bus;
    end
    always @(posedge clk) begin
        logic [12:0] r;
        r = nearest(in_s, dp_cent_m);
        if (force_max) r[9:0] = 10'h3FF;
        for (int i = LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
        pipe[0] <= en_s ? r : 13'h1555;
    end
    assign dp_index    = pipe[LAT-1][12:10];
    assign dp_distance = pipe[LAT-1][9:0];

    // Frame-level model and the single compare process.
    logic [12:0] exp_q [$];
    bit          busy_m = 1'b0;
    longint      sum_m = 0;
    int          outstanding = 0, acc = 0, num_pix_m = 0, cyc = 0;
    int          n_clear = 0, n_cen = 0, n_ifen = 0, n_res = 0, n_done = 0;
    int          last_acc = 0, done_cyc = 0;

    always @(negedge clk) begin
        logic [12:0] e;
        cyc++;
        if (rst) begin
            check("outputs_in_reset",
                  {busy, done, res_valid, pix_ready, cent_ready, dp_clear, dp_c_en, dp_if_en,
                   |dp_c_bus, |dp_if_in, |res_index, |res_distance, |dist_sum}, 0);
            exp_q.delete();
            busy_m = 0; sum_m = 0; outstanding = 0; acc = 0;
        end else begin
            check("busy", busy, busy_m);
            check("dist_sum", dist_sum, sum_m);
            check("dp_if_en", dp_if_en, pix_valid && pix_ready);
            if (pix_ready) begin
                check("pix_ready_room", outstanding < FIFO_DEPTH, 1);
                check("pix_ready_count", acc < num_pix_m, 1);
            end
            if (pix_valid && pix_ready) begin
                check("dp_if_in", dp_if_in, pix_data);
                e = nearest(pix_data, cent_tab);
                if (force_max) e[9:0] = 10'h3FF;
                exp_q.push_back(e);
                acc++; outstanding++; n_ifen++;
                last_acc = cyc;
            end
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", {res_index, res_distance}, 13'h1FFF);
                end else begin
                    e = exp_q.pop_front();
                    check("result", {res_index, res_distance}, e);
                    sum_m += longint'(e[9:0]);
                    if (sum_m > SUM_MAX) sum_m = SUM_MAX;
                end
                outstanding--; n_res++;
            end
            if (dp_clear) n_clear++;
            if (dp_c_en) begin
                n_cen++;
                check("dp_c_bus_hi", dp_c_bus[191:96], cent_tab[191:96]);
                check("dp_c_bus_lo", dp_c_bus[95:0], cent_tab[95:0]);
            end
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
            if (!busy_m && start) begin
                busy_m = 1; sum_m = 0; acc = 0; num_pix_m = int'(num_pix);
                n_clear = 0; n_cen = 0; n_ifen = 0; n_res = 0; n_done = 0;
            end else if (done) begin
                busy_m = 0;
            end
        end
    end

    task automatic pulse_start(input int n);
        start = 1; num_pix = NPIX_W'(n);
        @(posedge clk); #1;
        start = 0;
    endtask

    task automatic load_cents();
        bit ok;
        for (int k = 0; k < 8; k++) begin
            ok = 0;
            cent_valid = 1; cent_data = cent_tab[24*k +: 24];
            for (int t = 0; t < 50 && !ok; t++) begin
                @(negedge clk); ok = cent_ready;
                @(posedge clk); #1;
            end
            check("cent_beat_taken", ok, 1);
        end
        cent_valid = 0;
    endtask

    task automatic feed(input int n, input int sel, input int raise_at, input int start_at,
                        output int taken);
        bit took;
        taken = 0; pix_valid = 1; pix_data = pix_pat(sel, 0);
        for (int c = 0; c < 70000 && taken < n; c++) begin
            @(negedge clk); took = pix_ready;
            @(posedge clk); #1;
            if (took) begin
                taken++;
                pix_data = pix_pat(sel, taken);
            end
            if (c == raise_at) begin
                check("accepts_before_stall", taken, FIFO_DEPTH);
                res_ready = 1;
            end
            start = (c == start_at);
        end
        pix_valid = 0; start = 0;
        check("pixels_taken", taken, n);
    endtask

    task automatic wait_done(input int budget);
        bit ok;
        ok = 0;
        for (int c = 0; c < budget && !ok; c++) begin
            @(negedge clk); ok = done;
        end
        @(posedge clk); #1;
        check("done_seen", ok, 1);
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int     taken;
        longint s;
        logic [12:0] r;
        rst = 1; start = 1; num_pix = 5; cent_valid = 0; cent_data = 0;
        pix_valid = 0; pix_data = 0; res_ready = 1;
        for (int k = 0; k < 8; k++) cent_tab[24*k +: 24] = 24'(k * 32'h010101);
        repeat (3) @(posedge clk);
        #1; rst = 0; start = 0;
        repeat (2) @(posedge clk);
        #1;

        // Frame A: ramp centroids, four pixels, results streamed out immediately.
        check("model_pin_mid", nearest(24'h030405, cent_tab), {3'd4, 10'd2});
        check("model_pin_white", nearest(24'hFFFFFF, cent_tab), {3'd7, 10'd744});
        pulse_start(4);
        load_cents();
        feed(4, 0, -1, -1, taken);
        wait_done(50);
        check("a_clear_pulses", n_clear, 1);
        check("a_c_en_pulses", n_cen, 1);
        check("a_results", n_res, 4);
        check("a_done_latency", done_cyc - last_acc, LAT + 2);
        check("a_dist_sum", dist_sum, 746);

        // Frame B: back-pressure from the result side.
        for (int k = 0; k < 8; k++)
            cent_tab[24*k +: 24] = {8'(k * 32), 8'(255 - k * 32), 8'(k * 16 + 8)};
        res_ready = 0;
        pulse_start(10);
        load_cents();
        feed(10, 1, 30, -1, taken);
        wait_done(100);
        s = 0;
        for (int i = 0; i < 10; i++) begin
            r = nearest(pix_pat(1, i), cent_tab);
            s += longint'(r[9:0]);
        end
        check("b_results", n_res, 10);
        check("b_dist_sum", dist_sum, s);

        // Empty frame.
        pulse_start(0);
        load_cents();
        wait_done(50);
        check("z_if_en_count", n_ifen, 0);
        check("z_done_pulses", n_done, 1);
        check("z_dist_sum", dist_sum, 0);

        // Reset in the middle of a frame with results still in flight.
        pulse_start(6);
        load_cents();
        feed(4, 1, -1, -1, taken);
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        check("r_busy", busy, 0);
        check("r_res_valid", res_valid, 0);
        check("r_dist_sum", dist_sum, 0);
        repeat (6) @(posedge clk);
        #1;
        pulse_start(2);
        load_cents();
        feed(2, 2, -1, -1, taken);
        wait_done(50);
        check("r_results_after_restart", n_res, 2);

        // Large frame at maximum distance, with a stray start mid-run.
        force_max = 1;
        pulse_start(BIG_N);
        load_cents();
        feed(BIG_N, 2, -1, 100, taken);
        wait_done(100);
        check("s_dist_sum", dist_sum, SUM_MAX);
        check("s_results", n_res, BIG_N);
        check("s_clear_pulses", n_clear, 1);
        force_max = 0;

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/kmeans_ctrl.md
KMEANS_CTRL -- requirements
Module: kmeans_ctrl

Interface
REQ-001 SHALL have parameter LAT, default 2: cycles from dp_if_en asserted to valid dp_index/dp_distance.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: result FIFO entries, at least LAT+1.
REQ-003 SHALL have parameter NPIX_W, default 16: pixel-count width.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have ports start (input, 1) and num_pix (input, NPIX_W): frame start pulse and pixel count, sampled at start.
REQ-007 SHALL have ports cent_valid (input, 1), cent_ready (output, 1) and cent_data (input, 24): centroid RGB stream.
REQ-008 SHALL have ports pix_valid (input, 1), pix_ready (output, 1) and pix_data (input, 24): pixel RGB stream.
REQ-009 SHALL have ports dp_clear, dp_c_en and dp_if_en (output, 1 each), dp_c_bus (output, 192; centroid k at bits [24k+23:24k]) and dp_if_in (output, 24): drive the distance/min datapath.
REQ-010 SHALL have ports dp_index (input, 3) and dp_distance (input, 10): results returned by the datapath.
REQ-011 SHALL have ports res_valid (output, 1), res_ready (input, 1), res_index (output, 3) and res_distance (output, 10): per-pixel result stream.
REQ-012 SHALL have ports busy (output, 1), done (output, 1, one-cycle pulse) and dist_sum (output, 26): status and running sum of result distances.

Function
REQ-013 SHALL use states IDLE, CLEAR, LOAD_C, RUN, DRAIN and DONE.
REQ-014 IDLE: start=1 SHALL latch num_pix, zero dist_sum and pixel counters, and go to CLEAR; start in any other state SHALL be ignored.
REQ-015 CLEAR SHALL assert dp_clear for exactly one cycle, then go to LOAD_C.
REQ-016 LOAD_C SHALL hold cent_ready=1 and store beats 0..7 in order into centroid registers.
REQ-017 After the 8th beat, dp_c_en SHALL pulse for one cycle with the full dp_c_bus, then the block SHALL go to RUN; dp_c_bus SHALL hold its value until the next LOAD_C.
REQ-018 RUN: pix_ready SHALL be 1 only while issued<num_pix and (FIFO occupancy + in-flight) < FIFO_DEPTH.
REQ-019 On each pix_valid&&pix_ready cycle, dp_if_en=1 and dp_if_in=pix_data in that same cycle, and issued SHALL increment.
REQ-020 An LAT-deep valid shift register SHALL track in-flight pixels; when its tail is 1, dp_index/dp_distance SHALL be pushed into the FIFO, so overflow is impossible by construction.
REQ-021 The FIFO SHALL present res_valid when non-empty, pop on res_valid&&res_ready, keep results in order, and allow a push and pop in the same cycle (occupancy unchanged).
REQ-022 Each pop SHALL add res_distance to dist_sum, zero-extended, saturating at 2^26-1.
REQ-023 RUN SHALL go to DRAIN when issued==num_pix; DRAIN SHALL go to DONE when in-flight and FIFO are both empty; num_pix=0 SHALL pass through RUN and DRAIN with no pixel accepted.
REQ-024 DONE SHALL pulse done for one cycle, then go to IDLE; dist_sum SHALL hold until the next start.
REQ-025 busy SHALL be 1 in every state except IDLE.

Reset
REQ-026 rst SHALL set state=IDLE and clear FIFO, in-flight register, counters, centroid registers and dist_sum.
REQ-027 During rst, every output SHALL be 0; rst SHALL override start, and in-flight results SHALL be discarded when rst occurs mid-frame.

Structure
REQ-028 A shared package SHALL hold RGB_W=24, DIST_W=10, IDX_W=3, NUM_CENT=8 and the state enumeration.
REQ-029 The result FIFO SHALL be one sub-module, res_fifo, parameterised on depth and width (13 bits).

Verification
REQ-030 Load centroids 0x000000..0x070707, 4 pixels, LAT=2, res_ready=1: exactly one dp_clear and one dp_c_en pulse; 4 results in order; done 2+LAT cycles after the last accept.
REQ-031 res_ready=0, 10 pixels offered: pix_ready drops after exactly FIFO_DEPTH accepts; no result lost.
REQ-032 Raising res_ready then gives all 10 results in order, and dist_sum equals the model sum.
REQ-033 num_pix=0: done pulses after the 8 centroid beats and dp_if_en never asserts.
REQ-034 rst asserted mid-RUN with 2 results in flight: next cycle state=IDLE, res_valid=0 and dist_sum=0; no stale result appears after restart.
REQ-035 Forced dp_distance=1023 on every pixel with a large frame: dist_sum saturates at 0x3FFFFFF; start pulsed during RUN is ignored.
